// File: rtl/lwram_ctrl.sv
// LWRAM controller: bridges DRAM bus strobes to a req/ready memory port.
// Writes are posted through a small FIFO; reads stall the CPU via WAIT_N.
module lwram_ctrl #(
  parameter int ADDR_W     = 19,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE_R,
  input  logic              CE_F,
  input  logic [ADDR_W-1:0] A,
  input  logic [15:0]       DI,
  output logic [15:0]       DO,
  input  logic              DCE_N,
  input  logic              DOE_N,
  input  logic [1:0]        DWE_N,
  output logic              WAIT_N,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [15:0]       MEM_DIN,
  output logic [1:0]        MEM_BE,
  output logic              MEM_RD,
  output logic              MEM_WR,
  input  logic              MEM_RDY,
  input  logic [15:0]       MEM_DOUT
);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + 18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDONE
  } state_t;

  state_t            r_state;
  logic [EW-1:0]     r_buf [WBUF_DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [CW-1:0]     r_cnt;
  logic              r_rd_old;
  logic              r_wr_old;
  logic              r_rd_pend;
  logic              r_stall;
  logic              r_hold_v;
  logic [EW-1:0]     r_hold;
  logic [ADDR_W-1:0] r_rd_addr;

  logic          w_rd_term;
  logic          w_wr_term;
  logic          w_rd_start;
  logic          w_wr_start;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_wr_stall;
  logic [EW-1:0] w_wr_ent;
  logic [EW-1:0] w_push_ent;
  logic          w_unused;

  // Bus phase enables only matter to the CPU side sampling WAIT_N.
  assign w_unused = CE_R ^ CE_F;

  assign w_rd_term  = ~DCE_N & ~DOE_N;
  assign w_wr_term  = ~DCE_N & ~&DWE_N;
  assign w_rd_start = RST_N & w_rd_term & ~r_rd_old;
  assign w_wr_start = RST_N & w_wr_term & ~r_wr_old;

  assign w_full     = (r_cnt == CW'(WBUF_DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_wr_ent   = {A, DI, ~DWE_N};
  assign w_wr_stall = w_wr_start & w_full;

  // A parked write always goes in before any new one.
  assign w_push     = ~w_full & (r_hold_v | w_wr_start);
  assign w_push_ent = r_hold_v ? r_hold : w_wr_ent;
  assign w_pop      = (r_state == S_WR) & MEM_RDY;

  assign WAIT_N = ~(r_stall | w_rd_start | w_wr_stall);

  always_ff @(posedge CLK) begin
    if (w_push) r_buf[r_wp] <= w_push_ent;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_rd_old  <= 1'b0;
      r_wr_old  <= 1'b0;
      r_rd_pend <= 1'b0;
      r_stall   <= 1'b0;
      r_hold_v  <= 1'b0;
      r_hold    <= '0;
      r_rd_addr <= '0;
      DO        <= '0;
      MEM_ADDR  <= '0;
      MEM_DIN   <= '0;
      MEM_BE    <= '0;
      MEM_RD    <= 1'b0;
      MEM_WR    <= 1'b0;
    end else begin
      r_rd_old <= w_rd_term;
      r_wr_old <= w_wr_term;

      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase

      if (w_wr_stall && !r_hold_v) begin
        r_hold_v <= 1'b1;
        r_hold   <= w_wr_ent;
        r_stall  <= 1'b1;
      end else if (r_hold_v && !w_full) begin
        r_hold_v <= 1'b0;
        r_stall  <= 1'b0;
      end

      if (w_rd_start) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= A;
        r_stall   <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state <= S_WR;
            MEM_WR  <= 1'b1;
            {MEM_ADDR, MEM_DIN, MEM_BE} <= r_buf[r_rp];
          end else if (r_rd_pend) begin
            r_state  <= S_RD;
            MEM_RD   <= 1'b1;
            MEM_ADDR <= r_rd_addr;
            MEM_BE   <= 2'b11;
          end
        end
        S_WR: begin
          if (MEM_RDY) begin
            MEM_WR  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RD: begin
          if (MEM_RDY) begin
            MEM_RD  <= 1'b0;
            DO      <= MEM_DOUT;
            r_state <= S_RDONE;
          end
        end
        S_RDONE: begin
          r_state   <= S_IDLE;
          r_rd_pend <= 1'b0;
          r_stall   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
